// File: rtl/viterbi_frame_sched.sv
// Shares one Viterbi decoder core between two serial coded-bit channels:
// per-channel framing, round-robin issue with timeout, per-channel result serializers.
module viterbi_frame_sched #(
    parameter int CODE_LEN = 14,
    parameter int INFO_LEN = 7,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk1,
    input  logic                reset,
    input  logic                ch0_valid,
    input  logic                ch0_bit,
    input  logic                ch1_valid,
    input  logic                ch1_bit,
    output logic                core_start,
    output logic [CODE_LEN-1:0] core_code,
    input  logic                core_done,
    input  logic [INFO_LEN-1:0] core_data,
    output logic                ch0_out_valid,
    output logic                ch0_out_bit,
    output logic                ch1_out_valid,
    output logic                ch1_out_bit,
    output logic                ch0_drop,
    output logic                ch1_drop,
    output logic                timeout_err
);

    localparam int CW = $clog2(CODE_LEN);
    localparam int RW = $clog2(INFO_LEN);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESULT} state_t;

    logic [1:0]                   in_valid, in_bit;
    logic [1:0][CW-1:0]           cnt_q;
    logic [1:0][CODE_LEN-1:0]     shreg_q, buf_q;
    logic [1:0]                   pend_q, drop_q;

    state_t                       state_q;
    logic                         grant_q, last_grant_q, grant_d;
    logic [3:0]                   timer_q;
    logic [INFO_LEN-1:0]          res_q;
    logic                         start_q, tmo_q;
    logic [CODE_LEN-1:0]          code_q;

    logic [1:0]                   ser_vld_q, ser_bit_q;
    logic [1:0][INFO_LEN-2:0]     ser_sh_q;
    logic [1:0][RW-1:0]           ser_rem_q;

    logic [1:0]                   issue_clr, ser_load;

    assign in_valid = {ch1_valid, ch0_valid};
    assign in_bit   = {ch1_bit, ch0_bit};

    always_comb begin
        grant_d   = (pend_q == 2'b11) ? ~last_grant_q : pend_q[1];
        issue_clr = '0;
        ser_load  = '0;
        if (state_q == S_ISSUE)
            issue_clr[grant_q] = 1'b1;
        if (state_q == S_RESULT && !ser_vld_q[grant_q])
            ser_load[grant_q] = 1'b1;
    end

    // A completion landing on the ISSUE edge of the same channel is accepted:
    // the set of pend overrides the clear, and buf takes the new frame.
    always_ff @(posedge clk1) begin
        if (reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
            buf_q   <= '0;
            pend_q  <= '0;
            drop_q  <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                drop_q[c] <= 1'b0;
                if (issue_clr[c])
                    pend_q[c] <= 1'b0;
                if (!in_valid[c]) begin
                    cnt_q[c] <= '0;
                end else if (cnt_q[c] == CW'(CODE_LEN-1)) begin
                    cnt_q[c] <= '0;
                    if (!pend_q[c] || issue_clr[c]) begin
                        buf_q[c]  <= {in_bit[c], shreg_q[c][CODE_LEN-2:0]};
                        pend_q[c] <= 1'b1;
                    end else begin
                        drop_q[c] <= 1'b1;
                    end
                end else begin
                    shreg_q[c][cnt_q[c]] <= in_bit[c];
                    cnt_q[c]             <= cnt_q[c] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (reset) begin
            state_q      <= S_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            res_q        <= '0;
            start_q      <= 1'b0;
            code_q       <= '0;
            tmo_q        <= 1'b0;
        end else begin
            start_q <= 1'b0;
            tmo_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (|pend_q) begin
                        grant_q <= grant_d;
                        start_q <= 1'b1;
                        code_q  <= buf_q[grant_d];
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    last_grant_q <= grant_q;
                    timer_q      <= '0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        res_q   <= core_data;
                        state_q <= S_RESULT;
                    end else if (timer_q == 4'(TIMEOUT-1)) begin
                        tmo_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (timer_q != 4'hF) begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (!ser_vld_q[grant_q])
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Serializer: MSB of the result goes out first, INFO_LEN cycles back to back.
    always_ff @(posedge clk1) begin
        if (reset) begin
            ser_vld_q <= '0;
            ser_bit_q <= '0;
            ser_sh_q  <= '0;
            ser_rem_q <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (ser_load[c]) begin
                    ser_vld_q[c] <= 1'b1;
                    ser_bit_q[c] <= res_q[INFO_LEN-1];
                    ser_sh_q[c]  <= res_q[INFO_LEN-2:0];
                    ser_rem_q[c] <= RW'(INFO_LEN-1);
                end else if (ser_rem_q[c] != '0) begin
                    ser_bit_q[c] <= ser_sh_q[c][INFO_LEN-2];
                    ser_sh_q[c]  <= {ser_sh_q[c][INFO_LEN-3:0], 1'b0};
                    ser_rem_q[c] <= ser_rem_q[c] - 1'b1;
                end else begin
                    ser_vld_q[c] <= 1'b0;
                    ser_bit_q[c] <= 1'b0;
                end
            end
        end
    end

    assign core_start    = start_q;
    assign core_code     = code_q;
    assign timeout_err   = tmo_q;
    assign ch0_drop      = drop_q[0];
    assign ch1_drop      = drop_q[1];
    assign ch0_out_valid = ser_vld_q[0];
    assign ch0_out_bit   = ser_bit_q[0];
    assign ch1_out_valid = ser_vld_q[1];
    assign ch1_out_bit   = ser_bit_q[1];

endmodule

// File: doc/viterbi_frame_sched.md
Name: viterbi_frame_sched

Overview:
Schedules one shared 14-bit-frame Viterbi decoder core between two serial coded-bit channels. Each channel's serial stream is framed into 14-bit code words, and frames are granted to the core round-robin. Each 7-bit decoded result is returned to its own channel as a serial bit stream. The block sits between the channel receivers and the decoder core, replacing per-channel decoder instances.

Parameters:
CODE_LEN, 14, coded bits per frame (rate-1/2 code, 7 info bits)
INFO_LEN, 7, decoded bits per frame returned by the core
TIMEOUT, 15, maximum cycles from core_start to core_done before the frame is abandoned

Ports:
clk1  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
ch0_valid  in  1  ch0 coded bit present this cycle
ch0_bit  in  1  ch0 coded bit
ch1_valid  in  1  ch1 coded bit present this cycle
ch1_bit  in  1  ch1 coded bit
core_start  out  1  one-cycle pulse; the core latches core_code on this cycle
core_code  out  CODE_LEN  frame presented to the core, first-received bit at [0]
core_done  in  1  one-cycle pulse from the core; core_data valid on the same cycle
core_data  in  INFO_LEN  decoded bits, first info bit at [INFO_LEN-1]
ch0_out_valid  out  1  ch0 decoded bit present
ch0_out_bit  out  1  ch0 decoded bit
ch1_out_valid  out  1  ch1 decoded bit present
ch1_out_bit  out  1  ch1 decoded bit
ch0_drop  out  1  pulse: completed ch0 frame discarded because its buffer was full
ch1_drop  out  1  pulse: same for ch1
timeout_err  out  1  pulse: core did not answer within TIMEOUT

Behaviour:
- Reset (synchronous, active-high) clears the following:
  - all outputs, counters, buffers and pend flags;
  - FSM goes to IDLE;
  - last_grant set to ch1, so ch0 wins the first tie.
- Reset mid-operation abandons any in-flight frame; a later core_done is ignored because the FSM is in IDLE.
- Capture, per channel:
  - Shift register fills LSB-first: the k-th valid bit lands in bit [k].
  - A 4-bit counter runs 0..13 and advances only on cycles where valid is high.
  - Valid low for any cycle clears the counter and discards the partial frame.
  - On the 14th bit the frame is complete. If pend[ch]=0, the frame is copied to buf[ch], pend[ch] is set and the counter wraps to 0.
  - If pend[ch]=1 at completion, the frame is discarded, ch_drop pulses for 1 cycle and buf[ch] is kept.
- Arbiter FSM:
  - IDLE: if neither pend flag is set, stay. If exactly one is set, grant that channel. If both are set, grant the channel that is not last_grant. Record grant, go to ISSUE.
  - ISSUE (1 cycle): core_start=1 and core_code=buf[grant]. pend[grant] is cleared at the end of the cycle and last_grant<=grant. Go to WAIT with the timer cleared.
  - WAIT: on core_done, latch core_data into res and go to RESULT. The timer increments each cycle; when it reaches TIMEOUT without done, timeout_err pulses, the frame is lost and the FSM returns to IDLE.
  - RESULT: when the granted channel's serializer is idle, load res into it and go to IDLE. Otherwise hold in RESULT; the other channel's pending frame waits.
- core_code holds its last value outside ISSUE.
- core_done is ignored outside WAIT.
- Simultaneous completion and issue on the same channel: the pend clear from ISSUE and the pend set from completion collide. Set wins, and buf takes the new frame after the edge. The core sees the old frame during ISSUE.
- Serializer, per channel:
  - On load, out_valid is high for exactly INFO_LEN consecutive cycles starting the next cycle.
  - out_bit emits res[6] first, then res[5] down to res[0].
  - When idle, out_valid=0 and out_bit=0.
- Latency:
  - frame completion to core_start is 2 cycles when the FSM is idle;
  - core_done to first out_valid is 2 cycles when the serializer is idle.
- Widths: the timer is 4 bits and saturates; the counter compare is exact at CODE_LEN-1.

Test Plan:
- Single frame: 14 valid ch0 bits 0,0,1,1,0,1,... -> core_start 2 cycles after the last bit with core_code equal to the captured frame (first bit at [0]). Core returns 7'b1011001 after 5 cycles -> ch0_out_valid high for 7 cycles carrying bits 1,0,1,1,0,0,1.
- Both channels complete on the same cycle after reset -> ch0 is issued first, then ch1 after ch0's RESULT. With both pending again, ch0 is granted next (alternation).
- Core stalls with no done for TIMEOUT=15 cycles -> timeout_err pulses once, the FSM is back in IDLE, the next pending frame issues, and no ch out_valid occurs for the lost frame.
- ch1 sends a second full frame while its first is still pending (core held busy) -> ch1_drop pulses on the 14th bit, and the first frame is decoded and output unchanged.
- ch0 valid drops after 9 bits, then 14 fresh bits are sent -> only the 14 fresh bits form the frame in core_code. Assert reset during WAIT, then pulse core_done -> all outputs 0 and no serializer output.
